// File: rtl/eth_filter_pkg.sv
// Shared types and helpers for the receive-path frame filter.
package eth_filter_pkg;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StOut0,
        StOut1,
        StPass,
        StDrop
    } filt_state_t;

    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int unsigned ETH_HDR_BYTES = 14;

    // Destination MAC from beat 0; wire byte 0 lands in the MSB.
    function automatic logic [47:0] extract_dst(input logic [63:0] beat);
        return {beat[7:0], beat[15:8], beat[23:16], beat[31:24], beat[39:32], beat[47:40]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/eth_rx_filter.sv
// RX frame filter: buffers two header beats, decides pass/drop on destination MAC and
// EtherType, then replays the header and passes the rest of the frame through.
module eth_rx_filter
    import eth_filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,

    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,

    input  logic [47:0]             cfg_mac,
    input  logic                    cfg_promisc,
    input  logic                    cfg_accept_bcast,
    input  logic                    cfg_accept_mcast,
    input  logic                    cfg_etype_en,
    input  logic [15:0]             cfg_etype,

    output logic [CNT_WIDTH-1:0]    pass_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic [CNT_WIDTH-1:0]    runt_cnt
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH != 64) begin : g_width_check
        $error("eth_rx_filter supports only DATA_WIDTH = 64");
    end

    filt_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] b0_data_q, b1_data_q;
    logic [KEEP_WIDTH-1:0] b0_keep_q, b1_keep_q;
    logic                  b1_last_q;

    logic        pass_inc, drop_inc, runt_inc;
    logic [47:0] dst;
    logic [15:0] etype;
    logic        is_bcast, addr_ok, type_ok, frame_pass, hdr1_runt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHdr0;
            b0_data_q <= '0;
            b0_keep_q <= '0;
            b1_data_q <= '0;
            b1_keep_q <= '0;
            b1_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StHdr0 && s_tvalid) begin
                b0_data_q <= s_tdata;
                b0_keep_q <= s_tkeep;
            end
            if (state_q == StHdr1 && s_tvalid) begin
                b1_data_q <= s_tdata;
                b1_keep_q <= s_tkeep;
                b1_last_q <= s_tlast;
            end
        end
    end

    // Destination comes from the buffered beat 0, EtherType from the live beat 1.
    assign dst        = extract_dst(b0_data_q);
    assign etype      = {s_tdata[39:32], s_tdata[47:40]};
    assign is_bcast   = (dst == BCAST_MAC);
    assign addr_ok    = cfg_promisc | (dst == cfg_mac) | (is_bcast & cfg_accept_bcast) |
                        (dst[40] & ~is_bcast & cfg_accept_mcast);
    assign type_ok    = ~cfg_etype_en | (etype == cfg_etype);
    assign frame_pass = addr_ok & type_ok;
    // Byte 13 (last header byte) sits in lane 5 of beat 1.
    assign hdr1_runt  = s_tlast & ~s_tkeep[ETH_HDR_BYTES - 9];

    always_comb begin
        state_d  = state_q;
        s_tready = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        pass_inc = 1'b0;
        drop_inc = 1'b0;
        runt_inc = 1'b0;

        case (state_q)
            StHdr0: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    if (s_tlast) begin
                        runt_inc = 1'b1;
                    end else begin
                        state_d = StHdr1;
                    end
                end
            end
            StHdr1: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    if (hdr1_runt) begin
                        runt_inc = 1'b1;
                        state_d  = StHdr0;
                    end else if (frame_pass) begin
                        state_d = StOut0;
                    end else if (s_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = StHdr0;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StOut0: begin
                m_tvalid = 1'b1;
                m_tdata  = b0_data_q;
                m_tkeep  = b0_keep_q;
                if (m_tready) begin
                    state_d = StOut1;
                end
            end
            StOut1: begin
                m_tvalid = 1'b1;
                m_tdata  = b1_data_q;
                m_tkeep  = b1_keep_q;
                m_tlast  = b1_last_q;
                if (m_tready) begin
                    if (b1_last_q) begin
                        pass_inc = 1'b1;
                        state_d  = StHdr0;
                    end else begin
                        state_d = StPass;
                    end
                end
            end
            StPass: begin
                s_tready = m_tready;
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                m_tlast  = s_tlast;
                if (s_tvalid && m_tready && s_tlast) begin
                    pass_inc = 1'b1;
                    state_d  = StHdr0;
                end
            end
            StDrop: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = StHdr0;
                end
            end
            default: state_d = StHdr0;
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pass_inc),
        .cnt (pass_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_runt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (runt_inc),
        .cnt (runt_cnt)
    );

endmodule
